// File: rtl/uart_rx_fifo_pkg.sv
// Shared UART constants for the receive path.
// Parameter defaults of the receive FIFO refer to these values.
package uart_rx_fifo_pkg;

  localparam int UART_DATA_W         = 8;
  localparam int UART_RX_FIFO_DEPTH  = 16;
  localparam int UART_RX_FIFO_THRESH = 1;

endpackage

// File: rtl/uart_rx_fifo.sv
// Receive byte FIFO between the UART receiver and the control block.
// First-word-fall-through head, occupancy, threshold interrupt and sticky overrun.
module uart_rx_fifo
  import uart_rx_fifo_pkg::*;
#(
  parameter int DEPTH  = UART_RX_FIFO_DEPTH,
  parameter int WIDTH  = UART_DATA_W,
  parameter int THRESH = UART_RX_FIFO_THRESH
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     rx_end,
  input  logic [WIDTH-1:0]         rx_data,
  input  logic                     pop,
  input  logic                     flush,
  input  logic                     ovr_clr,
  output logic [WIDTH-1:0]         rd_data,
  output logic                     empty,
  output logic                     full,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     overrun,
  output logic                     irq_rx
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem_r [DEPTH];
  logic [AW-1:0]    wp_r;
  logic [AW-1:0]    rp_r;
  logic [CW-1:0]    count_r;
  logic             overrun_r;

  logic             empty_s;
  logic             full_s;
  logic             push_s;
  logic             pop_s;
  logic             drop_s;
  logic [AW-1:0]    wp_nxt_s;
  logic [AW-1:0]    rp_nxt_s;
  logic [CW-1:0]    count_nxt_s;
  logic             overrun_nxt_s;

  assign empty_s = (count_r == {CW{1'b0}});
  assign full_s  = (count_r == CW'(DEPTH));

  // Qualify strobes; a full FIFO still accepts a byte when the head leaves in the same cycle.
  always_comb begin
    push_s = 1'b0;
    pop_s  = 1'b0;
    drop_s = 1'b0;
    if (flush) begin
      push_s = 1'b0;
      pop_s  = 1'b0;
      drop_s = 1'b0;
    end else begin
      pop_s  = pop & ~empty_s;
      push_s = rx_end & (~full_s | pop);
      drop_s = rx_end & full_s & ~pop;
    end
  end

  // Next-state for pointers, occupancy and the sticky overrun flag.
  always_comb begin
    wp_nxt_s      = wp_r;
    rp_nxt_s      = rp_r;
    count_nxt_s   = count_r;
    overrun_nxt_s = overrun_r;
    if (flush) begin
      wp_nxt_s    = {AW{1'b0}};
      rp_nxt_s    = {AW{1'b0}};
      count_nxt_s = {CW{1'b0}};
    end else begin
      if (push_s) begin
        wp_nxt_s = wp_r + AW'(1'b1);
      end else begin
        wp_nxt_s = wp_r;
      end
      if (pop_s) begin
        rp_nxt_s = rp_r + AW'(1'b1);
      end else begin
        rp_nxt_s = rp_r;
      end
      if (push_s && !pop_s) begin
        count_nxt_s = count_r + CW'(1'b1);
      end else if (pop_s && !push_s) begin
        count_nxt_s = count_r - CW'(1'b1);
      end else begin
        count_nxt_s = count_r;
      end
    end
    // A fresh drop outranks a clear arriving in the same cycle.
    if (drop_s) begin
      overrun_nxt_s = 1'b1;
    end else if (ovr_clr) begin
      overrun_nxt_s = 1'b0;
    end else begin
      overrun_nxt_s = overrun_r;
    end
  end

  // Control state registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wp_r      <= {AW{1'b0}};
      rp_r      <= {AW{1'b0}};
      count_r   <= {CW{1'b0}};
      overrun_r <= 1'b0;
    end else begin
      wp_r      <= wp_nxt_s;
      rp_r      <= rp_nxt_s;
      count_r   <= count_nxt_s;
      overrun_r <= overrun_nxt_s;
    end
  end

  // Entry storage; contents are don't-care until written so no reset is needed.
  always_ff @(posedge clk) begin
    if (push_s) begin
      mem_r[wp_r] <= rx_data;
    end
  end

  assign rd_data = empty_s ? {WIDTH{1'b0}} : mem_r[rp_r];
  assign empty   = empty_s;
  assign full    = full_s;
  assign count   = count_r;
  assign overrun = overrun_r;
  assign irq_rx  = (count_r >= CW'(THRESH));

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Directed scoreboard bench for uart_rx_fifo (DEPTH 16, WIDTH 8, THRESH 1).
module tb_uart_rx_fifo;

  logic       clk = 1'b0;
  logic       reset;
  logic       rx_end, pop, flush, ovr_clr;
  logic [7:0] rx_data;
  logic [7:0] rd_data;
  logic       empty, full, overrun, irq_rx;
  logic [4:0] count;

  int n_asserts = 0;
  int n_fail    = 0;

  logic [7:0] exp_q [$];
  logic       m_ovr;

  uart_rx_fifo dut (
    .clk(clk), .reset(reset), .rx_end(rx_end), .rx_data(rx_data),
    .pop(pop), .flush(flush), .ovr_clr(ovr_clr), .rd_data(rd_data),
    .empty(empty), .full(full), .count(count), .overrun(overrun), .irq_rx(irq_rx)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_asserts++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_state(input string tag);
    logic [7:0] head;
    head = (exp_q.size() != 0) ? exp_q[0] : 8'h00;
    check({tag, ".count"},   32'(count),   32'(exp_q.size()));
    check({tag, ".empty"},   32'(empty),   32'(exp_q.size() == 0));
    check({tag, ".full"},    32'(full),    32'(exp_q.size() == 16));
    check({tag, ".rd_data"}, 32'(rd_data), 32'(head));
    check({tag, ".overrun"}, 32'(overrun), 32'(m_ovr));
    check({tag, ".irq_rx"},  32'(irq_rx),  32'(exp_q.size() >= 1));
  endtask

  // One clock with the given strobes; the scoreboard is updated from its own queue.
  task automatic cyc(input string tag, input logic r, input logic [7:0] d,
                     input logic p, input logic f, input logic oc);
    int  sz;
    logic [7:0] popped;
    sz = exp_q.size();
    rx_end = r; rx_data = d; pop = p; flush = f; ovr_clr = oc;
    if (f) begin
      exp_q.delete();
      if (oc) m_ovr = 1'b0;
    end else begin
      if (p && sz != 0) begin
        popped = exp_q.pop_front();
        check({tag, ".pop_head"}, 32'(rd_data), 32'(popped));
      end
      if (r && (sz != 16 || p)) exp_q.push_back(d);
      if (r && sz == 16 && !p) m_ovr = 1'b1;
      else if (oc) m_ovr = 1'b0;
    end
    @(posedge clk);
    #1;
    rx_end = 1'b0; pop = 1'b0; flush = 1'b0; ovr_clr = 1'b0; rx_data = 8'h00;
    check_state(tag);
  endtask

  initial begin
    reset = 1'b0; rx_end = 1'b0; rx_data = 8'h00; pop = 1'b0; flush = 1'b0; ovr_clr = 1'b0;
    m_ovr = 1'b0;
    #1;
    check_state("reset_async");
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check_state("idle");

    cyc("pop_empty", 1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
    cyc("push_a5",   1'b1, 8'hA5, 1'b0, 1'b0, 1'b0);
    cyc("push_3c",   1'b1, 8'h3C, 1'b0, 1'b0, 1'b0);
    cyc("pop1",      1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
    cyc("pop2",      1'b0, 8'h00, 1'b1, 1'b0, 1'b0);

    for (int i = 0; i < 17; i++) cyc("fill17", 1'b1, 8'(i), 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 16; i++) cyc("drain16", 1'b0, 8'h00, 1'b1, 1'b0, 1'b0);

    for (int i = 0; i < 16; i++) cyc("refill", 1'b1, 8'(8'h20 + i), 1'b0, 1'b0, 1'b0);
    cyc("full_push_pop", 1'b1, 8'h77, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 16; i++) cyc("drain_wrap", 1'b0, 8'h00, 1'b1, 1'b0, 1'b0);

    cyc("empty_push_pop", 1'b1, 8'h5A, 1'b1, 1'b0, 1'b0);
    cyc("flush_push",     1'b1, 8'hEE, 1'b0, 1'b1, 1'b0);

    cyc("ovr_clr_alone0", 1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 16; i++) cyc("fill_b", 1'b1, 8'(8'h40 + i), 1'b0, 1'b0, 1'b0);
    cyc("drop_vs_clr",  1'b1, 8'h99, 1'b0, 1'b0, 1'b1);
    cyc("ovr_clr_alone", 1'b0, 8'h00, 1'b0, 1'b0, 1'b1);

    for (int i = 0; i < 200; i++)
      cyc("sustain", 1'($urandom_range(0, 1)), 8'($urandom), 1'($urandom_range(0, 1)), 1'b0, 1'b0);

    cyc("flush_clean", 1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 5; i++) cyc("hold5", 1'b1, 8'(8'hC0 + i), 1'b0, 1'b0, 1'b0);
    reset = 1'b0;
    exp_q.delete();
    m_ovr = 1'b0;
    #1;
    check_state("mid_reset");
    @(negedge clk);
    reset = 1'b1;
    cyc("post_reset_push", 1'b1, 8'h11, 1'b0, 1'b0, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
    $finish;
  end

endmodule
